seg7_mux_reader: RTL and testbench

- Reader end of the team's multiplexed 7-segment display bus: it samples the active-low segment lines and the one-hot digit select, and decodes each digit back to a 4-bit hex value.
- Used for on-board self-check and bench loopback of display drivers: the driver side encodes switch values onto HEX segments, and this block recovers those values.
- Applies a per-pattern stability filter, flags illegal patterns, and flags a dead bus.

---
 rtl/seg7_mux_reader_if.sv | 24 ++
 rtl/seg7_mux_reader.sv | 129 ++++++++++++
 tb/tb_seg7_mux_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_reader_if.sv
// rtl/seg7_mux_reader_if.sv - display bus sampled by the 7-segment reader and its decoded results
interface seg7_mux_reader_if #(
  parameter int NDIG = 2
);
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   digit_valid;
  logic [NDIG-1:0]   digit_blank;
  logic [NDIG-1:0]   pat_err;
  logic              update;
  logic [2:0]        update_idx;
  logic              bus_alive;

  modport master (
    output seg_n, dig_sel,
    input  value, digit_valid, digit_blank, pat_err, update, update_idx, bus_alive
  );

  modport slave (
    input  seg_n, dig_sel,
    output value, digit_valid, digit_blank, pat_err, update, update_idx, bus_alive
  );
endinterface

// File: rtl/seg7_mux_reader.sv
// rtl/seg7_mux_reader.sv - multiplexed 7-segment bus reader with stability filter and dead-bus flag
module seg7_mux_reader #(
  parameter int NDIG        = 2,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  seg7_mux_reader_if.slave bus
);
  localparam int          TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  STABLE = 8'(STABLE_CYC);

  logic [NDIG+6:0]   r_prev;
  logic [7:0]        r_run;
  logic [4*NDIG-1:0] r_value;
  logic [NDIG-1:0]   r_valid;
  logic [NDIG-1:0]   r_blank;
  logic [NDIG-1:0]   r_err;
  logic              r_update;
  logic [2:0]        r_idx;
  logic              r_alive;
  logic [TW-1:0]     r_tcnt;

  logic [7:0] w_run_nxt;
  logic       w_onehot;
  logic       w_same;
  logic       w_accept;
  logic [2:0] w_idx;
  logic [4:0] w_dec;
  logic       w_blank;

  // Returns {legal, nibble}; legal=0 for anything outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    w_onehot  = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - NDIG'(1))) == '0);
    w_same    = ({bus.dig_sel, bus.seg_n} == r_prev);
    w_dec     = decode(bus.seg_n);
    w_blank   = (bus.seg_n == 7'h7F);
    w_run_nxt = 8'd1;
    if (!w_onehot) begin
      w_run_nxt = 8'd0;
    end else if (w_same && (r_run != 8'd0)) begin
      w_run_nxt = (r_run == STABLE) ? STABLE : r_run + 8'd1;
    end
    // The run is accepted only on the edge it first reaches STABLE, never while saturated.
    w_accept  = w_onehot && (w_run_nxt == STABLE) && (r_run != STABLE);
    w_idx     = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (bus.dig_sel[i]) begin
        w_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev   <= '0;
      r_run    <= '0;
      r_value  <= '0;
      r_valid  <= '0;
      r_blank  <= '0;
      r_err    <= '0;
      r_update <= 1'b0;
      r_idx    <= '0;
      r_alive  <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_prev   <= {bus.dig_sel, bus.seg_n};
      r_run    <= w_run_nxt;
      r_update <= w_accept;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_tcnt  <= '0;
        r_alive <= 1'b1;
        for (int i = 0; i < NDIG; i++) begin
          if (bus.dig_sel[i]) begin
            if (w_dec[4]) begin
              r_value[4*i +: 4] <= w_dec[3:0];
              r_valid[i]        <= 1'b1;
              r_blank[i]        <= 1'b0;
              r_err[i]          <= 1'b0;
            end else begin
              r_valid[i] <= 1'b0;
              r_blank[i] <= w_blank;
              r_err[i]   <= !w_blank;
            end
          end
        end
      end else begin
        if (r_tcnt != TW'(TIMEOUT_CYC)) begin
          r_tcnt <= r_tcnt + TW'(1);
        end
        if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          r_alive <= 1'b0;
        end
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.digit_valid = r_valid;
  assign bus.digit_blank = r_blank;
  assign bus.pat_err     = r_err;
  assign bus.update      = r_update;
  assign bus.update_idx  = r_idx;
  assign bus.bus_alive   = r_alive;
endmodule

// File: tb/tb_seg7_mux_reader.sv
// tb/tb_seg7_mux_reader.sv - scoreboard bench for seg7_mux_reader against a behavioural model
module tb_seg7_mux_reader;
  localparam int NDIG = 2;
  localparam int S    = 4;
  localparam int T    = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_mux_reader_if #(.NDIG(NDIG)) bus ();

  seg7_mux_reader #(.NDIG(NDIG), .STABLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0] idx;
    logic [7:0] value;
    logic [1:0] valid;
    logic [1:0] blank;
    logic [1:0] err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [8:0] m_last;
  int         m_run;
  logic [7:0] m_value;
  logic [1:0] m_valid, m_blank, m_err;
  int         m_since;
  bit         m_ever;
  bit         exp_alive;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = '0; m_run = 0; m_value = '0; m_valid = '0; m_blank = '0; m_err = '0;
    m_since = 0; m_ever = 0; exp_alive = 0;
    q.delete();
  endtask

  // Applies one sampling edge of the display bus to the reference model.
  task automatic model_edge(input logic [1:0] d, input logic [6:0] s);
    bit   accept;
    int   idx;
    int   hex;
    exp_t e;
    accept = 0;
    if ($countones(d) != 1) begin
      m_run = 0;
    end else if (m_run > 0 && {d, s} == m_last) begin
      if (m_run < S) begin
        m_run++;
        accept = (m_run == S);
      end
    end else begin
      m_run = 1;
    end
    m_last = {d, s};
    if (accept) begin
      idx = d[1] ? 1 : 0;
      hex = -1;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == s) hex = k;
      if (hex >= 0) begin
        m_value[4*idx +: 4] = 4'(hex);
        m_valid[idx] = 1; m_blank[idx] = 0; m_err[idx] = 0;
      end else if (s == 7'h7F) begin
        m_valid[idx] = 0; m_blank[idx] = 1; m_err[idx] = 0;
      end else begin
        m_valid[idx] = 0; m_blank[idx] = 0; m_err[idx] = 1;
      end
      e.idx = 3'(idx); e.value = m_value; e.valid = m_valid; e.blank = m_blank; e.err = m_err;
      q.push_back(e);
      m_since = 0;
      m_ever  = 1;
    end else begin
      m_since++;
    end
    exp_alive = m_ever && (m_since < T);
  endtask

  task automatic step(input logic [1:0] d, input logic [6:0] s);
    @(negedge clk);
    bus.dig_sel = d;
    bus.seg_n   = s;
    model_edge(d, s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n       = 1'b1;
    bus.dig_sel = 2'b00;
    model_edge(2'b00, bus.seg_n);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.value, bus.digit_valid, bus.digit_blank, bus.pat_err,
                 bus.update, bus.update_idx, bus.bus_alive}, 32'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("bus_alive", bus.bus_alive, exp_alive);
      if (bus.update || q.size() > 0) begin
        check("update", bus.update, q.size() > 0);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("update_idx", bus.update_idx, mon_e.idx);
          check("value", bus.value, mon_e.value);
          check("digit_valid", bus.digit_valid, mon_e.valid);
          check("digit_blank", bus.digit_blank, mon_e.blank);
          check("pat_err", bus.pat_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    logic [1:0] d;
    logic [6:0] s;
    int         r;
    bus.dig_sel = 2'b00;
    bus.seg_n   = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    release_reset();

    repeat (4) step(2'b01, 7'h24);
    settle();
    check("t1_value", bus.value[3:0], 4'h2);
    check("t1_valid", bus.digit_valid, 2'b01);
    check("t1_alive", bus.bus_alive, 1'b1);

    for (int rep = 0; rep < 2; rep++) begin
      repeat (10) step(2'b01, 7'h79);
      repeat (10) step(2'b10, 7'h0E);
    end
    settle();
    check("t2_value", bus.value, 8'hF1);
    check("t2_valid", bus.digit_valid, 2'b11);

    repeat (6) step(2'b10, 7'h7F);
    settle();
    check("t3_blank", bus.digit_blank, 2'b10);
    check("t3_valid", bus.digit_valid, 2'b01);
    check("t3_value_hi", bus.value[7:4], 4'hF);
    repeat (6) step(2'b10, 7'h55);
    settle();
    check("t3_err", bus.pat_err, 2'b10);

    repeat (3) step(2'b01, 7'h40);
    repeat (4) step(2'b01, 7'h12);
    settle();
    check("t4_value", bus.value[3:0], 4'h5);
    repeat (10) step(2'b11, 7'h40);

    repeat (300) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      r = $urandom_range(0, 19);
      s = (r < 12) ? seg_tab[$urandom_range(0, 15)] : (r < 15) ? 7'h7F : 7'($urandom);
      repeat ($urandom_range(1, 7)) step(d, s);
    end
    settle();
    check("rand_value", bus.value, m_value);
    check("rand_valid", bus.digit_valid, m_valid);
    check("rand_blank", bus.digit_blank, m_blank);
    check("rand_err", bus.pat_err, m_err);

    repeat (4) step(2'b01, 7'h40);
    repeat (T - 1) step(2'b00, 7'h7F);
    settle();
    check("to_alive_before", bus.bus_alive, 1'b1);
    step(2'b00, 7'h7F);
    settle();
    check("to_alive_after", bus.bus_alive, 1'b0);
    check("to_value_kept", bus.value, m_value);
    check("to_nibble0_kept", bus.value[3:0], 4'h0);
    check("to_valid_kept", bus.digit_valid, m_valid);

    repeat (2) step(2'b01, 7'h24);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    release_reset();
    repeat (3) step(2'b10, 7'h19);
    settle();
    check("rst_no_early_upd", bus.update, 1'b0);
    step(2'b10, 7'h19);
    settle();
    check("rst_restart_value", bus.value, 8'h40);
    check("rst_restart_valid", bus.digit_valid, 2'b10);

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
